// File: rtl/mem_stage_pkg.sv
// Shared widths, opcode map and memory-stage FSM encoding for the pipeline.
// Opcode-class helpers keep the decode of "memory" and "control-flow" ops in one place.
package mem_stage_pkg;

  localparam int unsigned REG_WIDTH    = 16;
  localparam int unsigned OPCODE_WIDTH = 8;
  localparam int unsigned PC_WIDTH     = 16;

  localparam logic [OPCODE_WIDTH-1:0] OP_ADD_D  = 8'h00;
  localparam logic [OPCODE_WIDTH-1:0] OP_ADDI_D = 8'h01;
  localparam logic [OPCODE_WIDTH-1:0] OP_AND_D  = 8'h02;
  localparam logic [OPCODE_WIDTH-1:0] OP_MOV    = 8'h03;
  localparam logic [OPCODE_WIDTH-1:0] OP_LDW    = 8'h10;
  localparam logic [OPCODE_WIDTH-1:0] OP_STW    = 8'h11;
  localparam logic [OPCODE_WIDTH-1:0] OP_BRN    = 8'h20;
  localparam logic [OPCODE_WIDTH-1:0] OP_BRZ    = 8'h21;
  localparam logic [OPCODE_WIDTH-1:0] OP_BRP    = 8'h22;
  localparam logic [OPCODE_WIDTH-1:0] OP_BRNZP  = 8'h23;
  localparam logic [OPCODE_WIDTH-1:0] OP_JMP    = 8'h28;
  localparam logic [OPCODE_WIDTH-1:0] OP_JSR    = 8'h29;
  localparam logic [OPCODE_WIDTH-1:0] OP_JSRR   = 8'h2A;

  typedef enum logic {
    MEM_ST_IDLE = 1'b0,
    MEM_ST_WAIT = 1'b1
  } mem_state_e;

  function automatic logic is_mem_op(input logic [OPCODE_WIDTH-1:0] op);
    return (op == OP_LDW) || (op == OP_STW);
  endfunction

  function automatic logic is_branch_op(input logic [OPCODE_WIDTH-1:0] op);
    return (op == OP_BRN) || (op == OP_BRZ) || (op == OP_BRP) || (op == OP_BRNZP) ||
           (op == OP_JMP) || (op == OP_JSR) || (op == OP_JSRR);
  endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Loadable up-counter bounding how long the memory stage waits for an ack.
// Updates on the falling clock edge to match the rest of the pipeline.
module mem_timeout_ctr #(
  parameter int unsigned Timeout = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned CntW = $clog2(Timeout);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(negedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == CntW'(Timeout - 1));

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: issues LDW/STW over a req/ack port, redirects fetch on
// control-flow ops and forwards a registered bundle to writeback.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned DMEM_ADDR_WIDTH = 10,
  parameter int unsigned TIMEOUT         = 16
) (
  input  logic                       I_CLOCK,
  input  logic                       I_RESET_N,
  input  logic                       I_LOCK,
  input  logic [REG_WIDTH-1:0]       I_ALUOut,
  input  logic [OPCODE_WIDTH-1:0]    I_Opcode,
  input  logic [3:0]                 I_DestRegIdx,
  input  logic [REG_WIDTH-1:0]       I_DestValue,
  input  logic                       I_FetchStall,
  input  logic                       I_DepStall,
  input  logic                       I_DMemAck,
  input  logic [REG_WIDTH-1:0]       I_DMemRData,
  output logic                       O_DMemReq,
  output logic                       O_DMemWe,
  output logic [DMEM_ADDR_WIDTH-1:0] O_DMemAddr,
  output logic [REG_WIDTH-1:0]       O_DMemWData,
  output logic                       O_MemStall,
  output logic                       O_BranchValid,
  output logic [PC_WIDTH-1:0]        O_BranchPC,
  output logic                       O_LOCK,
  output logic [REG_WIDTH-1:0]       O_ALUOut,
  output logic [REG_WIDTH-1:0]       O_MemOut,
  output logic [OPCODE_WIDTH-1:0]    O_Opcode,
  output logic [3:0]                 O_DestRegIdx,
  output logic                       O_FetchStall,
  output logic                       O_DepStall,
  output logic                       O_MemError
);

  mem_state_e                 state_q, state_d;
  logic                       req_q, req_d;
  logic                       we_q, we_d;
  logic [DMEM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [REG_WIDTH-1:0]       wdata_q, wdata_d;
  logic                       mem_stall_q, mem_stall_d;
  logic                       br_valid_q, br_valid_d;
  logic [PC_WIDTH-1:0]        br_pc_q, br_pc_d;
  logic                       lock_q, lock_d;
  logic [REG_WIDTH-1:0]       alu_q, alu_d;
  logic [REG_WIDTH-1:0]       mem_out_q, mem_out_d;
  logic [OPCODE_WIDTH-1:0]    opcode_q, opcode_d;
  logic [3:0]                 dest_q, dest_d;
  logic                       fstall_q, fstall_d;
  logic                       dstall_q, dstall_d;
  logic                       err_q, err_d;
  // Instruction captured at issue so writeback sees it even if upstream inputs drift.
  logic [REG_WIDTH-1:0]       hold_alu_q, hold_alu_d;
  logic [OPCODE_WIDTH-1:0]    hold_op_q, hold_op_d;
  logic [3:0]                 hold_dest_q, hold_dest_d;

  logic valid_in;
  logic ctr_load, ctr_en, ctr_tc;

  assign valid_in = I_LOCK & ~I_FetchStall & ~I_DepStall;

  mem_timeout_ctr #(
    .Timeout (TIMEOUT)
  ) u_timeout_ctr (
    .clk_i  (I_CLOCK),
    .rst_ni (I_RESET_N),
    .load_i (ctr_load),
    .en_i   (ctr_en),
    .tc_o   (ctr_tc)
  );

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    mem_stall_d = mem_stall_q;
    br_valid_d  = 1'b0;
    br_pc_d     = br_pc_q;
    lock_d      = lock_q;
    alu_d       = alu_q;
    mem_out_d   = mem_out_q;
    opcode_d    = opcode_q;
    dest_d      = dest_q;
    fstall_d    = fstall_q;
    dstall_d    = dstall_q;
    err_d       = err_q;
    hold_alu_d  = hold_alu_q;
    hold_op_d   = hold_op_q;
    hold_dest_d = hold_dest_q;
    ctr_load    = 1'b0;
    ctr_en      = 1'b0;

    unique case (state_q)
      MEM_ST_IDLE: begin
        lock_d   = I_LOCK;
        fstall_d = I_FetchStall;
        dstall_d = I_DepStall;
        if (valid_in) begin
          if (is_mem_op(I_Opcode)) begin
            req_d       = 1'b1;
            we_d        = (I_Opcode == OP_STW);
            addr_d      = I_ALUOut[DMEM_ADDR_WIDTH-1:0];
            wdata_d     = (I_Opcode == OP_STW) ? I_DestValue : '0;
            mem_stall_d = 1'b1;
            dstall_d    = 1'b1;
            hold_alu_d  = I_ALUOut;
            hold_op_d   = I_Opcode;
            hold_dest_d = I_DestRegIdx;
            ctr_load    = 1'b1;
            state_d     = MEM_ST_WAIT;
          end else begin
            alu_d    = I_ALUOut;
            opcode_d = I_Opcode;
            dest_d   = I_DestRegIdx;
            if (is_branch_op(I_Opcode)) begin
              br_valid_d = 1'b1;
              br_pc_d    = I_DestValue[PC_WIDTH-1:0];
            end
          end
        end
      end
      MEM_ST_WAIT: begin
        // Ack has priority over a timeout landing on the same edge.
        if (I_DMemAck || ctr_tc) begin
          req_d       = 1'b0;
          we_d        = 1'b0;
          addr_d      = '0;
          wdata_d     = '0;
          mem_stall_d = 1'b0;
          alu_d       = hold_alu_q;
          opcode_d    = hold_op_q;
          dest_d      = hold_dest_q;
          lock_d      = 1'b1;
          fstall_d    = 1'b0;
          dstall_d    = 1'b0;
          state_d     = MEM_ST_IDLE;
          if (I_DMemAck) begin
            if (hold_op_q == OP_LDW) begin
              mem_out_d = I_DMemRData;
            end
          end else begin
            err_d     = 1'b1;
            mem_out_d = '0;
          end
        end else begin
          ctr_en = 1'b1;
        end
      end
      default: state_d = MEM_ST_IDLE;
    endcase
  end

  always_ff @(negedge I_CLOCK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      state_q     <= MEM_ST_IDLE;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      mem_stall_q <= 1'b0;
      br_valid_q  <= 1'b0;
      br_pc_q     <= '0;
      lock_q      <= 1'b0;
      alu_q       <= '0;
      mem_out_q   <= '0;
      opcode_q    <= '0;
      dest_q      <= '0;
      fstall_q    <= 1'b0;
      dstall_q    <= 1'b0;
      err_q       <= 1'b0;
      hold_alu_q  <= '0;
      hold_op_q   <= '0;
      hold_dest_q <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      mem_stall_q <= mem_stall_d;
      br_valid_q  <= br_valid_d;
      br_pc_q     <= br_pc_d;
      lock_q      <= lock_d;
      alu_q       <= alu_d;
      mem_out_q   <= mem_out_d;
      opcode_q    <= opcode_d;
      dest_q      <= dest_d;
      fstall_q    <= fstall_d;
      dstall_q    <= dstall_d;
      err_q       <= err_d;
      hold_alu_q  <= hold_alu_d;
      hold_op_q   <= hold_op_d;
      hold_dest_q <= hold_dest_d;
    end
  end

  assign O_DMemReq     = req_q;
  assign O_DMemWe      = we_q;
  assign O_DMemAddr    = addr_q;
  assign O_DMemWData   = wdata_q;
  assign O_MemStall    = mem_stall_q;
  assign O_BranchValid = br_valid_q;
  assign O_BranchPC    = br_pc_q;
  assign O_LOCK        = lock_q;
  assign O_ALUOut      = alu_q;
  assign O_MemOut      = mem_out_q;
  assign O_Opcode      = opcode_q;
  assign O_DestRegIdx  = dest_q;
  assign O_FetchStall  = fstall_q;
  assign O_DepStall    = dstall_q;
  assign O_MemError    = err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage: a transaction-level model predicts the writeback
// bundle, memory-port activity and stall length of each instruction.
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam int unsigned AW = 10;
  localparam int unsigned TO = 16;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    i_lock = 1'b0, i_fs = 1'b0, i_ds = 1'b0, i_ack = 1'b0;
  logic [REG_WIDTH-1:0]    i_alu = '0, i_dval = '0, i_rdata = '0;
  logic [OPCODE_WIDTH-1:0] i_op = '0;
  logic [3:0]              i_dest = '0;

  logic                    o_req, o_we, o_stall, o_bv, o_lock, o_fs, o_ds, o_err;
  logic [AW-1:0]           o_addr;
  logic [REG_WIDTH-1:0]    o_wdata, o_alu, o_mem;
  logic [PC_WIDTH-1:0]     o_bpc;
  logic [OPCODE_WIDTH-1:0] o_op;
  logic [3:0]              o_dest;

  always #5 clk = ~clk;

  mem_stage #(
    .DMEM_ADDR_WIDTH (AW),
    .TIMEOUT         (TO)
  ) dut (
    .I_CLOCK       (clk),
    .I_RESET_N     (rst_n),
    .I_LOCK        (i_lock),
    .I_ALUOut      (i_alu),
    .I_Opcode      (i_op),
    .I_DestRegIdx  (i_dest),
    .I_DestValue   (i_dval),
    .I_FetchStall  (i_fs),
    .I_DepStall    (i_ds),
    .I_DMemAck     (i_ack),
    .I_DMemRData   (i_rdata),
    .O_DMemReq     (o_req),
    .O_DMemWe      (o_we),
    .O_DMemAddr    (o_addr),
    .O_DMemWData   (o_wdata),
    .O_MemStall    (o_stall),
    .O_BranchValid (o_bv),
    .O_BranchPC    (o_bpc),
    .O_LOCK        (o_lock),
    .O_ALUOut      (o_alu),
    .O_MemOut      (o_mem),
    .O_Opcode      (o_op),
    .O_DestRegIdx  (o_dest),
    .O_FetchStall  (o_fs),
    .O_DepStall    (o_ds),
    .O_MemError    (o_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: what writeback should currently see.
  logic [REG_WIDTH-1:0]    e_alu, e_mem;
  logic [OPCODE_WIDTH-1:0] e_op;
  logic [3:0]              e_dest;
  logic                    e_lock, e_fs, e_ds, e_err, e_bv;
  logic [PC_WIDTH-1:0]     e_bpc;

  logic [OPCODE_WIDTH-1:0] op_list [13];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit tb_mem(input logic [OPCODE_WIDTH-1:0] op);
    return op == OP_LDW || op == OP_STW;
  endfunction

  function automatic bit tb_branch(input logic [OPCODE_WIDTH-1:0] op);
    return op inside {OP_BRN, OP_BRZ, OP_BRP, OP_BRNZP, OP_JMP, OP_JSR, OP_JSRR};
  endfunction

  task automatic model_reset();
    e_alu = '0; e_mem = '0; e_op = '0; e_dest = '0; e_bpc = '0;
    e_lock = 0; e_fs = 0; e_ds = 0; e_err = 0; e_bv = 0;
  endtask

  task automatic check_outputs(input string tag, input bit exp_req, input bit exp_stall);
    check({tag, ".req"},   32'(o_req),   32'(exp_req));
    check({tag, ".stall"}, 32'(o_stall), 32'(exp_stall));
    check({tag, ".lock"},  32'(o_lock),  32'(e_lock));
    check({tag, ".fs"},    32'(o_fs),    32'(e_fs));
    check({tag, ".ds"},    32'(o_ds),    32'(e_ds));
    check({tag, ".alu"},   32'(o_alu),   32'(e_alu));
    check({tag, ".mem"},   32'(o_mem),   32'(e_mem));
    check({tag, ".op"},    32'(o_op),    32'(e_op));
    check({tag, ".dest"},  32'(o_dest),  32'(e_dest));
    check({tag, ".err"},   32'(o_err),   32'(e_err));
    check({tag, ".bv"},    32'(o_bv),    32'(e_bv));
    if (e_bv) check({tag, ".bpc"}, 32'(o_bpc), 32'(e_bpc));
  endtask

  task automatic check_reset(input string tag);
    check_outputs(tag, 1'b0, 1'b0);
    check({tag, ".we"},    32'(o_we),    32'd0);
    check({tag, ".addr"},  32'(o_addr),  32'd0);
    check({tag, ".wdata"}, 32'(o_wdata), 32'd0);
    check({tag, ".bpc0"},  32'(o_bpc),   32'd0);
  endtask

  // Called at a posedge; returns at the posedge where the instruction's result is visible.
  // ack_delay k in 1..TO acks on the k-th cycle after issue; anything else never acks.
  task automatic run_instr(input string tag, input logic lock, input logic fs, input logic ds,
                           input logic [OPCODE_WIDTH-1:0] op, input logic [REG_WIDTH-1:0] alu,
                           input logic [REG_WIDTH-1:0] dval, input logic [3:0] dest,
                           input int ack_delay, input logic [REG_WIDTH-1:0] rdata,
                           input bit idle_ack);
    bit valid;
    bit acked;
    valid  = lock && !fs && !ds;
    i_lock = lock; i_fs = fs; i_ds = ds; i_op = op; i_alu = alu; i_dval = dval;
    i_dest = dest; i_ack = idle_ack; i_rdata = $urandom;
    @(negedge clk); @(posedge clk);
    i_ack = 1'b0;
    if (valid && tb_mem(op)) begin
      e_bv = 0; e_lock = 1; e_fs = 0; e_ds = 1;
      acked = (ack_delay >= 1) && (ack_delay <= int'(TO));
      for (int k = 1; k <= int'(TO); k++) begin
        check_outputs({tag, ".wait"}, 1'b1, 1'b1);
        check({tag, ".addr"},  32'(o_addr),  32'(alu[AW-1:0]));
        check({tag, ".we"},    32'(o_we),    32'(op == OP_STW));
        check({tag, ".wdata"}, 32'(o_wdata), (op == OP_STW) ? 32'(dval) : 32'd0);
        // Upstream should hold, but the stage must not depend on it.
        i_alu = REG_WIDTH'($urandom); i_dval = REG_WIDTH'($urandom); i_op = OPCODE_WIDTH'($urandom);
        i_ack = (k == ack_delay);
        i_rdata = (k == ack_delay) ? rdata : REG_WIDTH'($urandom);
        @(negedge clk); @(posedge clk);
        i_ack = 1'b0;
        if (k == ack_delay) break;
      end
      e_alu = alu; e_op = op; e_dest = dest; e_ds = 0;
      if (acked) begin
        if (op == OP_LDW) e_mem = rdata;
      end else begin
        e_err = 1; e_mem = '0;
      end
      check_outputs({tag, ".done"}, 1'b0, 1'b0);
    end else begin
      e_lock = lock; e_fs = fs; e_ds = ds; e_bv = 0;
      if (valid) begin
        e_alu = alu; e_op = op; e_dest = dest;
        if (tb_branch(op)) begin
          e_bv = 1; e_bpc = dval[PC_WIDTH-1:0];
        end
      end
      check_outputs(tag, 1'b0, 1'b0);
    end
  endtask

  initial begin
    op_list = '{OP_ADD_D, OP_ADDI_D, OP_AND_D, OP_MOV, OP_LDW, OP_STW, OP_BRN, OP_BRZ,
                OP_BRP, OP_BRNZP, OP_JMP, OP_JSR, OP_JSRR};
    model_reset();
    #1 check_reset("reset_async");
    @(posedge clk); @(posedge clk);
    check_reset("reset_held");
    rst_n = 1'b1;

    run_instr("add",  1, 0, 0, OP_ADD_D, 16'h0012, 16'h0000, 4'd3, 0, 16'h0, 0);
    run_instr("ldw",  1, 0, 0, OP_LDW,   16'h0405, 16'h0000, 4'd5, 3, 16'hBEEF, 0);
    run_instr("stw",  1, 0, 0, OP_STW,   16'h0010, 16'h1234, 4'd0, 1, 16'h0, 0);
    run_instr("jmp",  1, 0, 0, OP_JMP,   16'h0000, 16'h0040, 4'd7, 0, 16'h0, 0);
    run_instr("bub",  1, 1, 0, OP_ADD_D, 16'h7777, 16'h0000, 4'd9, 0, 16'h0, 1);
    run_instr("tmo",  1, 0, 0, OP_LDW,   16'h0123, 16'h0000, 4'd2, 0, 16'h0, 0);
    run_instr("err_sticky", 1, 0, 0, OP_AND_D, 16'h00AA, 16'h0000, 4'd1, 0, 16'h0, 0);
    run_instr("ack_late", 1, 0, 0, OP_LDW, 16'hFFFF, 16'h0000, 4'd4, int'(TO), 16'h5A5A, 0);

    for (int n = 0; n < 150; n++) begin
      logic [OPCODE_WIDTH-1:0] op;
      int d;
      op = op_list[$urandom_range(0, 12)];
      d  = $urandom_range(0, 5) == 0 ? $urandom_range(0, TO + 2) : $urandom_range(1, 4);
      run_instr("rnd", $urandom_range(0, 7) != 0, $urandom_range(0, 7) == 0,
                $urandom_range(0, 7) == 0, op, REG_WIDTH'($urandom), REG_WIDTH'($urandom),
                4'($urandom), d, REG_WIDTH'($urandom), $urandom_range(0, 3) == 0);
    end

    // Reset while a load is outstanding must drop the request without waiting for a clock.
    i_lock = 1; i_fs = 0; i_ds = 0; i_op = OP_LDW; i_alu = 16'h0033; i_ack = 0;
    @(negedge clk); @(posedge clk);
    check("mid_wait.req_pre", 32'(o_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_reset("mid_wait_reset");
    @(posedge clk);
    rst_n = 1'b1;
    run_instr("post_rst", 1, 0, 0, OP_MOV, 16'h0101, 16'h0000, 4'd6, 0, 16'h0, 0);
    run_instr("post_ldw", 1, 0, 0, OP_LDW, 16'h03FF, 16'h0000, 4'd8, 2, 16'hC0DE, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
